// File: rtl/garage_door_plant.sv
// ---------------------------------------------------------------------------
// garage_door_plant
//
// Stand-in for the physical garage door. It takes the controller's motor
// commands and produces the limit switches, so the controller can run in a
// closed loop in simulation or on a demo board with no real door attached.
// Door position is an integer count that moves one step every STEP_DIV clock
// edges while a motor is energised. A sticky fault flag catches the illegal
// "both motors on" command.
//
// Parameters:
//   TRAVEL   - position count of the fully open door (closed is 0)
//   STEP_DIV - clock edges per position step (1 or more)
//   POS_W    - width of the position count
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-low reset (door returns to closed)
//   UP_M   in   raise-motor command
//   DN_M   in   lower-motor command
//   UP_MAX out  upper limit switch, high when POS == TRAVEL
//   DN_MAX out  lower limit switch, high when POS == 0
//   POS    out  current door position
//   MOVING out  high while the door is rising or falling
//   FAULT  out  sticky flag, set when both commands are seen high
// ---------------------------------------------------------------------------
module garage_door_plant #(
   parameter int TRAVEL   = 8,
   parameter int STEP_DIV = 4,
   parameter int POS_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             UP_M,
   input  logic             DN_M,
   output logic             UP_MAX,
   output logic             DN_MAX,
   output logic [POS_W-1:0] POS,
   output logic             MOVING,
   output logic             FAULT
);

   // A prescaler of one edge per step still needs a one-bit register.
   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [POS_W-1:0] TRAVEL_C = POS_W'(TRAVEL);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

   // One-hot motion state.
   typedef enum logic [2:0] {
      ST_STOPPED = 3'b100,
      ST_RISING  = 3'b010,
      ST_FALLING = 3'b001
   } state_t;

   state_t           r_state;
   logic [POS_W-1:0] r_pos;
   logic [DIV_W-1:0] r_div;
   logic             r_fault;

   logic [POS_W-1:0] w_posInc;
   logic [POS_W-1:0] w_posDec;
   logic             w_stepDue;

   assign w_posInc  = r_pos + POS_W'(1);
   assign w_posDec  = r_pos - POS_W'(1);
   assign w_stepDue = (r_div == DIV_LAST);

   // Door mechanics. A latched fault freezes everything until reset. Both
   // motors on latches the fault and stops the door where it is. Otherwise
   // the door moves one step per prescaler wrap in the commanded direction,
   // stops when it reaches a limit or the command drops, and reverses
   // immediately on the opposite command, discarding any partial step.
   // Reversal from a limit goes to STOPPED, because the door cannot move
   // further in that direction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_STOPPED;
         r_pos   <= '0;
         r_div   <= '0;
         r_fault <= 1'b0;
      end else if (r_fault) begin
         r_fault <= 1'b1;
      end else if (UP_M && DN_M) begin
         r_fault <= 1'b1;
         r_state <= ST_STOPPED;
         r_div   <= '0;
      end else begin
         case (r_state)
            ST_STOPPED: begin
               r_div <= '0;
               if (UP_M && (r_pos < TRAVEL_C)) begin
                  r_state <= ST_RISING;
               end else if (DN_M && (r_pos != '0)) begin
                  r_state <= ST_FALLING;
               end
            end
            ST_RISING: begin
               if (UP_M) begin
                  if (w_stepDue) begin
                     r_div <= '0;
                     if (r_pos < TRAVEL_C) begin
                        r_pos <= w_posInc;
                     end
                     if ((r_pos >= TRAVEL_C) || (w_posInc == TRAVEL_C)) begin
                        r_state <= ST_STOPPED;
                     end
                  end else begin
                     r_div <= r_div + DIV_W'(1);
                  end
               end else if (DN_M) begin
                  r_div   <= '0;
                  r_state <= (r_pos != '0) ? ST_FALLING : ST_STOPPED;
               end else begin
                  r_div   <= '0;
                  r_state <= ST_STOPPED;
               end
            end
            ST_FALLING: begin
               if (DN_M) begin
                  if (w_stepDue) begin
                     r_div <= '0;
                     if (r_pos != '0) begin
                        r_pos <= w_posDec;
                     end
                     if ((r_pos == '0) || (w_posDec == '0)) begin
                        r_state <= ST_STOPPED;
                     end
                  end else begin
                     r_div <= r_div + DIV_W'(1);
                  end
               end else if (UP_M) begin
                  r_div   <= '0;
                  r_state <= (r_pos < TRAVEL_C) ? ST_RISING : ST_STOPPED;
               end else begin
                  r_div   <= '0;
                  r_state <= ST_STOPPED;
               end
            end
            default: begin
               r_div   <= '0;
               r_state <= ST_STOPPED;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registers, so they only change after a
   // clock edge or on reset.
   assign UP_MAX = (r_pos == TRAVEL_C);
   assign DN_MAX = (r_pos == '0);
   assign POS    = r_pos;
   assign MOVING = (r_state == ST_RISING) || (r_state == ST_FALLING);
   assign FAULT  = r_fault;

endmodule

// File: tb/tb_garage_door_plant.sv
// ---------------------------------------------------------------------------
// tb_garage_door_plant
//
// Self-checking bench for garage_door_plant. Every cycle the stimulus task
// drives the motor commands, advances a behavioural door model and pushes the
// expected output word onto a scoreboard queue; after the clock edge the word
// is popped and compared with the DUT outputs.
// Output word layout: {UP_MAX, DN_MAX, POS[3:0], MOVING, FAULT}.
// ---------------------------------------------------------------------------
module tb_garage_door_plant;

   localparam int TRAVEL   = 8;
   localparam int STEP_DIV = 4;
   localparam int POS_W    = 4;

   logic             clock;
   logic             rst;
   logic             upM;
   logic             dnM;
   logic             upMax;
   logic             dnMax;
   logic [POS_W-1:0] pos;
   logic             moving;
   logic             fault;

   int errorCount;
   int checkCount;

   logic [7:0] expQueue[$];
   string      tagQueue[$];

   // Door model: modelDir 0 = stopped, 1 = rising, 2 = falling.
   int modelPos;
   int modelDiv;
   int modelDir;
   bit modelFault;

   garage_door_plant #(
      .TRAVEL  (TRAVEL),
      .STEP_DIV(STEP_DIV),
      .POS_W   (POS_W)
   ) dut (
      .clk   (clock),
      .rst   (rst),
      .UP_M  (upM),
      .DN_M  (dnM),
      .UP_MAX(upMax),
      .DN_MAX(dnMax),
      .POS   (pos),
      .MOVING(moving),
      .FAULT (fault)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got {upMax,dnMax,pos,moving,fault}=%b_%b_%0d_%b_%b expected %b_%b_%0d_%b_%b",
                  tag, observed[7], observed[6], observed[5:2], observed[1], observed[0],
                  expected[7], expected[6], expected[5:2], expected[1], expected[0]);
      end
   endtask

   function automatic logic [7:0] modelWord();
      logic [3:0] p;
      p = 4'(modelPos);
      return {modelPos == TRAVEL, modelPos == 0, p, modelDir != 0, modelFault};
   endfunction

   task automatic modelReset();
      modelPos   = 0;
      modelDiv   = 0;
      modelDir   = 0;
      modelFault = 1'b0;
   endtask

   // One clock edge of the door as seen from outside.
   task automatic modelStep(input bit up, input bit dn);
      bit towardUp;
      if (modelFault) return;
      if (up && dn) begin
         modelFault = 1'b1;
         modelDir   = 0;
         modelDiv   = 0;
         return;
      end
      if (modelDir == 0) begin
         modelDiv = 0;
         if (up && modelPos < TRAVEL) modelDir = 1;
         else if (dn && modelPos > 0) modelDir = 2;
         return;
      end
      towardUp = (modelDir == 1);
      if ((towardUp && up) || (!towardUp && dn)) begin
         if (modelDiv + 1 == STEP_DIV) begin
            modelDiv = 0;
            modelPos = towardUp ? modelPos + 1 : modelPos - 1;
            if (modelPos == TRAVEL || modelPos == 0) modelDir = 0;
         end else begin
            modelDiv++;
         end
      end else if (up || dn) begin
         modelDiv = 0;
         if (up) modelDir = (modelPos < TRAVEL) ? 1 : 0;
         else    modelDir = (modelPos > 0) ? 2 : 0;
      end else begin
         modelDiv = 0;
         modelDir = 0;
      end
   endtask

   // Pop one expected word and compare with the current DUT outputs.
   task automatic compareNext();
      logic [7:0] expWord;
      string      tag;
      if (expQueue.size() == 0) begin
         errorCount++;
         checkCount++;
         $display("[TB] FAIL scoreboard: queue empty, got %b expected an entry",
                  {upMax, dnMax, pos, moving, fault});
         return;
      end
      expWord = expQueue.pop_front();
      tag     = tagQueue.pop_front();
      checkOutput(tag, {upMax, dnMax, pos, moving, fault}, expWord);
   endtask

   // Drive commands for one cycle, predict, then check after the edge.
   task automatic applyStimulus(input bit up, input bit dn, input string tag);
      @(negedge clock);
      upM = up;
      dnM = dn;
      modelStep(up, dn);
      expQueue.push_back(modelWord());
      tagQueue.push_back(tag);
      @(posedge clock);
      #1;
      compareNext();
   endtask

   task automatic runCycles(input int n, input bit up, input bit dn, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(up, dn, tag);
   endtask

   // Hold reset across several edges with random commands.
   task automatic holdReset(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         rst = 1'b0;
         upM = 1'($urandom_range(0, 1));
         dnM = 1'($urandom_range(0, 1));
         modelReset();
         expQueue.push_back(modelWord());
         tagQueue.push_back(tag);
         @(posedge clock);
         #1;
         compareNext();
      end
      @(negedge clock);
      upM = 1'b0;
      dnM = 1'b0;
      rst = 1'b1;
   endtask

   initial begin
      errorCount = 0;
      checkCount = 0;
      rst = 1'b0;
      upM = 1'b0;
      dnM = 1'b0;
      modelReset();
      $display("[TB] garage_door_plant bench start");

      // Reset held with random commands, then release with no commands.
      holdReset(4, "reset");
      runCycles(3, 1'b0, 1'b0, "release");

      // Full open, then keep pushing against the upper limit.
      runCycles(36, 1'b1, 1'b0, "open");

      // Full close from open.
      runCycles(36, 1'b0, 1'b1, "close");

      // Open to position 3, drop the command, restart, then reverse.
      runCycles(13, 1'b1, 1'b0, "toPos3");
      runCycles(3, 1'b0, 1'b0, "midStop");
      runCycles(2, 1'b1, 1'b0, "restart");
      runCycles(6, 1'b0, 1'b1, "reverse");
      runCycles(2, 1'b0, 1'b0, "stop2");

      // Rise to position 4, assert both commands, then random commands.
      runCycles(9, 1'b1, 1'b0, "toPos4");
      applyStimulus(1'b1, 1'b1, "faultSet");
      for (int i = 0; i < 10; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "faultHold");
      holdReset(2, "faultClear");
      runCycles(2, 1'b0, 1'b0, "postFault");

      // Lower command at the closed limit is refused.
      runCycles(4, 1'b0, 1'b1, "limitRefuse");

      // Rise to position 5 and reset mid-cycle without waiting for an edge.
      runCycles(21, 1'b1, 1'b0, "toPos5");
      #2;
      rst = 1'b0;
      modelReset();
      expQueue.push_back(modelWord());
      tagQueue.push_back("asyncReset");
      #1;
      compareNext();
      @(negedge clock);
      upM = 1'b0;
      rst = 1'b1;
      runCycles(2, 1'b0, 1'b0, "afterAsync");

      if (expQueue.size() != 0) begin
         errorCount++;
         checkCount++;
         $display("[TB] FAIL scoreboard: %0d entries left, expected 0", expQueue.size());
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
